video_test_pattern_generator: RTL and testbench
===============================================

Name: video_test_pattern_generator

Overview:
- Pixel-colour client for the generator interface of the generator-source pipeline.
- Consumes hPos/vPos/dataEnable from the generator source and returns 8-bit r/g/b plus dataEnableDelayed after a fixed 2-cycle latency.
- Provides selectable test patterns (solid, colour bars, gradient, checkerboard, grid, moving bar, ramp) for bring-up of the scaler and timing sink.

Parameters:
HACTIVE_BITS, 11, width of hPos and sourceColumns
VACTIVE_BITS, 11, width of vPos
CHECKER_SHIFT, 4, log2 of checkerboard square and grid pitch in pixels

Ports:
scalerClock  input  1  single clock for all logic
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
hPos  input  HACTIVE_BITS  pixel column from generator source
vPos  input  VACTIVE_BITS  pixel row from generator source
dataEnable  input  1  hPos/vPos valid this cycle
patternSelect  input  3  requested pattern, 0..7
solidColor  input  24  {r,g,b} for pattern 0
sourceColumns  input  HACTIVE_BITS  active source width, used for bars and border
sourceRows  input  VACTIVE_BITS  active source height, used for border
r  output  8  red, valid when dataEnableDelayed=1
g  output  8  green
b  output  8  blue
dataEnableDelayed  output  1  dataEnable delayed exactly 2 cycles
barsReady  output  1  bar thresholds valid

Behaviour:
- Reset (reset=0, asynchronous): r/g/b=0, dataEnableDelayed=0, barsReady=0, frame counter=0, active pattern=0, active colour=0, threshold FSM=IDLE.
- Latency:
  - Stage 1 registers hPos, vPos and dataEnable, plus classification: bar index, checker bit, grid hit, border hit.
  - Stage 2 registers the colour.
  - Inputs at cycle N appear on outputs at N+2. Full throughput, one pixel per cycle, no stalls.
- When dataEnableDelayed=0, r/g/b are forced to 0.
- Frame start: a cycle with dataEnable=1 and vPos==0, when the previous dataEnable=1 cycle had vPos!=0 or no dataEnable has occurred since reset.
- At frame start:
  - patternSelect and solidColor are copied into the active registers. Mid-frame changes have no effect until the next frame start.
  - The frame counter (8-bit, wraps 255->0) increments.
  - The start pixel itself already uses the new active values.
- Patterns, keyed on the active pattern:
  - 0 solid: active colour.
  - 1 bars: 8 bars (white, yellow, cyan, green, magenta, red, blue, black). Bar index = count of thresholds T1..T7 that are <= hPos, where Tk = k*(sourceColumns>>3). hPos >= T7 is black. Output is black while barsReady=0.
  - 2 gradient: r=g=b=hPos[7:0].
  - 3 checker: white when (hPos>>CHECKER_SHIFT ^ vPos>>CHECKER_SHIFT) bit0 = 1, else black.
  - 4 grid: white when hPos[CHECKER_SHIFT-1:0]==0, vPos[CHECKER_SHIFT-1:0]==0, hPos==sourceColumns-1 or vPos==sourceRows-1; else 0x202020.
  - 5 moving bar: white when hPos[7:0] - frameCounter, as an 8-bit result, is < 16; else black.
  - 6 ramp: r=hPos[7:0], g=vPos[7:0], b=frameCounter.
  - 7: black.
- Threshold FSM (states IDLE, CALC):
  - Holds a shadow of sourceColumns. When reset deasserts, or in IDLE when sourceColumns != shadow: capture the shadow, set barsReady=0, enter CALC.
  - CALC runs 7 cycles, one per threshold: Tk = T(k-1) + (shadow>>3), with T0=0, adding with HACTIVE_BITS width.
  - After T7 is written: barsReady=1, return to IDLE.
  - A change of sourceColumns during CALC restarts CALC from k=1 on the next cycle.
  - sourceColumns < 8 gives all T=0, so every pixel is black in bars mode.
- Reset mid-operation clears the pipeline immediately. Any in-flight pixels are lost and dataEnableDelayed=0.

Optional Feature:
- Macro: VIDEO_TEST_PATTERN_ANIMATION_EN.
- Defined: frame counter implemented; patterns 5 and 6 behave as above.
- Undefined: no frame counter. Pattern 5 outputs black; pattern 6 outputs b=0 with r/g unchanged. Frame-start capture of patternSelect/solidColor still occurs.

Test Plan:
- Latency/reset: drive dataEnable=1 for 4 cycles at hPos 0..3, patternSelect=2 from reset. Expect dataEnableDelayed high exactly 2 cycles later for 4 cycles, r=0,1,2,3. Assert reset=0 mid-burst: outputs 0 immediately.
- Bars: sourceColumns=320. barsReady rises 8 cycles after reset release; T1..T7=40..280. hPos=39 gives white FFFFFF; hPos=40 gives yellow FFFF00; hPos=279 gives blue 0000FF; hPos=280 and hPos=319 give black.
- Bars recompute: change sourceColumns to 640 at cycle 3 of CALC. barsReady stays 0 until the restarted CALC completes; then T1=80.
- Pattern latch: switch patternSelect 0->3 mid-frame (vPos=100). Output stays solidColor until the next frame start at vPos=0. At that point the pixel (hPos=16, vPos=0) is white.
- Animation: pattern 6 over 3 frames gives b=1,2,3 at pixel (0,0). Frame counter at 255 wraps to 0. With the macro undefined, b=0 throughout.
- Grid/border: CHECKER_SHIFT=4, sourceRows=240. (17,17) gives 202020; (32,5) gives FFFFFF; (5,239) gives FFFFFF.

Source files
------------

// File: rtl/video_test_pattern_generator_if.sv
// Pixel stream between the generator source and a colour client: position and
// enable toward the client, colour and delayed enable back.
interface video_test_pattern_generator_if #(
    parameter int HACTIVE_BITS = 11,
    parameter int VACTIVE_BITS = 11
);
    logic [HACTIVE_BITS-1:0] hPos;
    logic [VACTIVE_BITS-1:0] vPos;
    logic                    dataEnable;
    logic [7:0]              r;
    logic [7:0]              g;
    logic [7:0]              b;
    logic                    dataEnableDelayed;

    modport master (output hPos, vPos, dataEnable, input  r, g, b, dataEnableDelayed);
    modport slave  (input  hPos, vPos, dataEnable, output r, g, b, dataEnableDelayed);
endinterface

// File: rtl/video_test_pattern_generator.sv
// Test pattern colour client, fixed 2-cycle latency, one pixel per clock.
// Define VIDEO_TEST_PATTERN_ANIMATION_EN to build the frame counter (moving bar, ramp blue).
module video_test_pattern_generator #(
    parameter int HACTIVE_BITS  = 11,
    parameter int VACTIVE_BITS  = 11,
    parameter int CHECKER_SHIFT = 4
) (
    input  logic                     scalerClock,
    input  logic                     reset,
    video_test_pattern_generator_if.slave pix,
    input  logic [2:0]               patternSelect,
    input  logic [23:0]              solidColor,
    input  logic [HACTIVE_BITS-1:0]  sourceColumns,
    input  logic [VACTIVE_BITS-1:0]  sourceRows,
    output logic                     barsReady
);
    localparam logic [23:0] WHITE = 24'hFFFFFF;
    localparam logic [HACTIVE_BITS-1:0] H_ONE = 1;
    localparam logic [VACTIVE_BITS-1:0] V_ONE = 1;

    typedef enum logic {IDLE, CALC} thr_state_t;

    thr_state_t                    state, state_nxt;
    logic [HACTIVE_BITS-1:0]       col_shadow, thr_acc, thr_step, thr_sum;
    logic [6:0][HACTIVE_BITS-1:0]  thr;
    logic [2:0]                    thr_k;
    logic                          calc_pending, thr_load, thr_wr;

    assign thr_step = col_shadow >> 3;
    assign thr_sum  = thr_acc + thr_step;

    always_ff @(posedge scalerClock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // A width change seen in CALC reloads the shadow and restarts from T1.
    always_comb begin
        state_nxt = state;
        thr_load  = 1'b0;
        thr_wr    = 1'b0;
        case (state)
            IDLE: if (calc_pending || sourceColumns != col_shadow) begin
                thr_load  = 1'b1;
                state_nxt = CALC;
            end
            CALC: if (sourceColumns != col_shadow) begin
                thr_load = 1'b1;
            end else begin
                thr_wr = 1'b1;
                if (thr_k == 3'd7) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge scalerClock or negedge reset) begin
        if (!reset) begin
            col_shadow   <= '0;
            thr_acc      <= '0;
            thr          <= '0;
            thr_k        <= 3'd1;
            barsReady    <= 1'b0;
            calc_pending <= 1'b1;
        end else if (thr_load) begin
            col_shadow   <= sourceColumns;
            thr_acc      <= '0;
            thr_k        <= 3'd1;
            barsReady    <= 1'b0;
            calc_pending <= 1'b0;
        end else if (thr_wr) begin
            thr[thr_k - 3'd1] <= thr_sum;
            thr_acc           <= thr_sum;
            thr_k             <= thr_k + 3'd1;
            if (thr_k == 3'd7) barsReady <= 1'b1;
        end
    end

    logic        v_zero, seen_de, prev_v_zero, frame_start;
    logic [2:0]  act_pat;
    logic [23:0] act_color;

    assign v_zero      = (pix.vPos == '0);
    assign frame_start = pix.dataEnable && v_zero && (!seen_de || !prev_v_zero);

    always_ff @(posedge scalerClock or negedge reset) begin
        if (!reset) begin
            seen_de     <= 1'b0;
            prev_v_zero <= 1'b0;
            act_pat     <= '0;
            act_color   <= '0;
        end else begin
            if (pix.dataEnable) begin
                seen_de     <= 1'b1;
                prev_v_zero <= v_zero;
            end
            if (frame_start) begin
                act_pat   <= patternSelect;
                act_color <= solidColor;
            end
        end
    end

`ifdef VIDEO_TEST_PATTERN_ANIMATION_EN
    logic [7:0] frame_cnt;
    always_ff @(posedge scalerClock or negedge reset) begin
        if (!reset)           frame_cnt <= '0;
        else if (frame_start) frame_cnt <= frame_cnt + 8'd1;
    end
`endif

    logic [2:0] bar_idx;
    always_comb begin
        bar_idx = '0;
        for (int k = 0; k < 7; k++)
            if (thr[k] <= pix.hPos) bar_idx = bar_idx + 3'd1;
    end

    logic [1:0]              vld_pipe;
    logic [HACTIVE_BITS-1:0] h1;
    logic [VACTIVE_BITS-1:0] v1;
    logic [2:0]              bar1;
    logic                    checker1, grid1, border1, ready1;

    always_ff @(posedge scalerClock or negedge reset) begin
        if (!reset) begin
            vld_pipe <= '0;
            h1       <= '0;
            v1       <= '0;
            bar1     <= '0;
            checker1 <= 1'b0;
            grid1    <= 1'b0;
            border1  <= 1'b0;
            ready1   <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[0], pix.dataEnable};
            h1       <= pix.hPos;
            v1       <= pix.vPos;
            bar1     <= bar_idx;
            checker1 <= pix.hPos[CHECKER_SHIFT] ^ pix.vPos[CHECKER_SHIFT];
            grid1    <= (pix.hPos[CHECKER_SHIFT-1:0] == '0) || (pix.vPos[CHECKER_SHIFT-1:0] == '0);
            border1  <= (pix.hPos == sourceColumns - H_ONE) || (pix.vPos == sourceRows - V_ONE);
            ready1   <= barsReady;
        end
    end

    logic [23:0] color;
`ifdef VIDEO_TEST_PATTERN_ANIMATION_EN
    logic [7:0] mb_off;
    assign mb_off = h1[7:0] - frame_cnt;
`endif

    always_comb begin
        color = '0;
        case (act_pat)
            3'd0: color = act_color;
            3'd1: if (ready1) begin
                case (bar1)
                    3'd0:    color = 24'hFFFFFF;
                    3'd1:    color = 24'hFFFF00;
                    3'd2:    color = 24'h00FFFF;
                    3'd3:    color = 24'h00FF00;
                    3'd4:    color = 24'hFF00FF;
                    3'd5:    color = 24'hFF0000;
                    3'd6:    color = 24'h0000FF;
                    default: color = 24'h000000;
                endcase
            end
            3'd2: color = {3{h1[7:0]}};
            3'd3: color = checker1 ? WHITE : 24'h000000;
            3'd4: color = (grid1 || border1) ? WHITE : 24'h202020;
`ifdef VIDEO_TEST_PATTERN_ANIMATION_EN
            3'd5: color = (mb_off < 8'd16) ? WHITE : 24'h000000;
            3'd6: color = {h1[7:0], v1[7:0], frame_cnt};
`else
            3'd6: color = {h1[7:0], v1[7:0], 8'h00};
`endif
            default: color = '0;
        endcase
    end

    always_ff @(posedge scalerClock or negedge reset) begin
        if (!reset) begin
            pix.r <= '0;
            pix.g <= '0;
            pix.b <= '0;
        end else begin
            {pix.r, pix.g, pix.b} <= vld_pipe[0] ? color : 24'h000000;
        end
    end

    assign pix.dataEnableDelayed = vld_pipe[1];
endmodule

// File: tb/tb_video_test_pattern_generator.sv
// Randomized bench for the test pattern generator with a spec-level colour model.
module tb_video_test_pattern_generator;
    localparam int HB = 11, VB = 11, CS = 4;

    logic scalerClock = 1'b0;
    logic reset = 1'b0;
    always #5 scalerClock = ~scalerClock;

    video_test_pattern_generator_if #(.HACTIVE_BITS(HB), .VACTIVE_BITS(VB)) pix ();
    logic [2:0]  patternSelect;
    logic [23:0] solidColor;
    logic [10:0] sourceColumns, sourceRows;
    logic        barsReady;

    video_test_pattern_generator #(.HACTIVE_BITS(HB), .VACTIVE_BITS(VB), .CHECKER_SHIFT(CS)) dut (
        .scalerClock  (scalerClock),
        .reset        (reset),
        .pix          (pix.slave),
        .patternSelect(patternSelect),
        .solidColor   (solidColor),
        .sourceColumns(sourceColumns),
        .sourceRows   (sourceRows),
        .barsReady    (barsReady)
    );

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s got %h exp %h", tag, obs, exp);
    endtask

    // model state
    bit          m_seen, m_prev0;
    int          m_pat, m_fc, since;
    logic [23:0] m_color;
    logic [24:0] exp0, exp1;
    logic [2:0]  ps_n;
    logic [23:0] sc_n;
    logic [10:0] cols_n, rows_n;

    function automatic logic [23:0] bar_rgb(input int idx);
        case (idx)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic logic [23:0] ref_color(input int h, input int v, input bit rdy);
        int cols = sourceColumns, rows = sourceRows, idx = 0, step, hb, vb;
        logic [7:0] h8, v8, f8;
        h8 = 8'(h); v8 = 8'(v); f8 = 8'(m_fc);
        case (m_pat)
            0: return m_color;
            1: begin
                if (!rdy) return 24'h0;
                step = cols / 8;
                for (int k = 1; k <= 7; k++) if (((k * step) % 2048) <= h) idx++;
                return bar_rgb(idx);
            end
            2: return {h8, h8, h8};
            3: begin
                hb = h / (1 << CS); vb = v / (1 << CS);
                return (((hb ^ vb) % 2) == 1) ? 24'hFFFFFF : 24'h0;
            end
            4: return ((h % (1 << CS)) == 0 || (v % (1 << CS)) == 0 ||
                       h == ((cols + 2047) % 2048) || v == ((rows + 2047) % 2048)) ? 24'hFFFFFF : 24'h202020;
`ifdef VIDEO_TEST_PATTERN_ANIMATION_EN
            5: return (((h - m_fc) % 256 + 256) % 256 < 16) ? 24'hFFFFFF : 24'h0;
            6: return {h8, v8, f8};
`else
            5: return 24'h0;
            6: return {h8, v8, 8'h00};
`endif
            default: return 24'h0;
        endcase
    endfunction

    task automatic model_clear();
        m_seen = 0; m_prev0 = 0; m_pat = 0; m_fc = 0; m_color = '0;
        exp0 = '0; exp1 = '0;
    endtask

    // One clock: check output of the pixel driven two cycles ago, then drive a new one.
    task automatic cycle(input bit de, input int h, input int v);
        @(negedge scalerClock);
        chk("pix", {7'd0, pix.dataEnableDelayed, pix.r, pix.g, pix.b}, {7'd0, exp1});
        chk("bars_ready", {31'd0, barsReady}, {31'd0, since >= 8});
        exp1 = exp0;
        patternSelect = ps_n; solidColor = sc_n; sourceRows = rows_n;
        if (cols_n != sourceColumns) since = 0;
        sourceColumns = cols_n;
        pix.dataEnable = de; pix.hPos = 11'(h); pix.vPos = 11'(v);
        if (de) begin
            if ((v % 2048) == 0 && (!m_seen || !m_prev0)) begin
                m_pat = ps_n; m_color = sc_n; m_fc = (m_fc + 1) % 256;
            end
            m_seen = 1; m_prev0 = ((v % 2048) == 0);
            exp0 = {1'b1, ref_color(h % 2048, v % 2048, since >= 8)};
        end else begin
            exp0 = '0;
        end
        if (since < 100) since++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0);
    endtask

    task automatic do_reset();
        @(posedge scalerClock);
        #2 reset = 1'b0;
        #1;
        chk("reset_out", {7'd0, pix.dataEnableDelayed, pix.r, pix.g, pix.b}, 32'd0);
        chk("reset_ready", {31'd0, barsReady}, 32'd0);
        model_clear();
        pix.dataEnable = 1'b0;
        repeat (2) @(posedge scalerClock);
        @(negedge scalerClock);
        reset = 1'b1;
        since = 1;
    endtask

    initial begin
        model_clear();
        ps_n = 3'd2; sc_n = '0; cols_n = 11'd320; rows_n = 11'd240;
        patternSelect = ps_n; solidColor = sc_n; sourceColumns = cols_n; sourceRows = rows_n;
        pix.dataEnable = 1'b0; pix.hPos = '0; pix.vPos = '0;
        repeat (3) @(posedge scalerClock);
        #1;
        chk("reset_out", {7'd0, pix.dataEnableDelayed, pix.r, pix.g, pix.b}, 32'd0);
        chk("reset_ready", {31'd0, barsReady}, 32'd0);
        @(negedge scalerClock);
        reset = 1'b1;
        since = 1;

        // latency: gradient from the first frame start
        for (int h = 0; h < 4; h++) cycle(1, h, 0);
        idle(8);

        // reset with pixels in flight
        for (int h = 10; h < 13; h++) cycle(1, h, 0);
        do_reset();
        ps_n = 3'd1;
        idle(10);

        // colour bars at 320 columns
        cycle(1, 0, 0);
        cycle(1, 39, 1); cycle(1, 40, 1); cycle(1, 279, 1);
        cycle(1, 280, 1); cycle(1, 319, 1);
        for (int i = 0; i < 20; i++) cycle(1, $urandom_range(0, 400), 1);
        idle(2);

        // width change, then another change three cycles into CALC
        cols_n = 11'd160; idle(3);
        cols_n = 11'd640; idle(10);
        cycle(1, 79, 1); cycle(1, 80, 1); cycle(1, 559, 1); cycle(1, 560, 1); cycle(1, 639, 1);
        idle(2);

        // tiny width: every bar threshold collapses to zero
        cols_n = 11'd5; idle(10);
        cycle(1, 0, 1); cycle(1, 3, 1);
        cols_n = 11'd640; idle(10);

        // grid and border
        ps_n = 3'd4;
        cycle(1, 0, 50); cycle(1, 0, 0);
        cycle(1, 17, 17); cycle(1, 32, 5); cycle(1, 5, 239); cycle(1, 639, 17);
        idle(2);

        // pattern latch at frame start only
        sc_n = 24'($urandom); ps_n = 3'd0;
        cycle(1, 0, 50); cycle(1, 0, 0); cycle(1, 5, 100);
        ps_n = 3'd3; sc_n = 24'($urandom);
        cycle(1, 16, 100); cycle(1, 20, 100);
        cycle(1, 16, 0); cycle(1, 0, 0);
        idle(2);

        // animation across counter wrap
        ps_n = 3'd6;
        for (int f = 0; f < 300; f++) begin cycle(1, 0, 0); cycle(1, 0, 1); end
        ps_n = 3'd5;
        for (int f = 0; f < 20; f++) begin
            cycle(1, $urandom_range(0, 255), 0);
            cycle(1, $urandom_range(0, 255), 1);
            cycle(1, $urandom_range(0, 255), 2);
        end
        idle(2);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                ps_n = 3'($urandom); sc_n = 24'($urandom);
            end
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2047),
                  ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 600));
        end
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
